// File: rtl/ftoi_pipe.sv
// Two-stage IEEE-754 single-precision to signed 32-bit integer converter, round-to-nearest-even.
// Define FTOI_FLAGS_EN to add the out_flags port ({invalid, inexact}).
module ftoi_pipe #(
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef FTOI_FLAGS_EN
    ,
    output logic [1:0]       out_flags
`endif
);

    localparam int unsigned W  = 32;
    localparam int unsigned MW = 24;

    logic s2_load;
    logic in_fire;

    logic          s1_valid;
    logic          s1_sign;
    logic          s1_sat;
    logic          s1_g;
    logic          s1_r;
    logic          s1_s;
    logic [W-1:0]  s1_mag;

    logic          d_sign;
    logic          d_sat;
    logic          d_g;
    logic          d_r;
    logic          d_s;
    logic [W-1:0]  d_mag;
    logic [7:0]    d_exp;
    logic [22:0]   d_frac;
    logic [MW-1:0] d_m;
    logic [3:0]    d_lsh_amt;
    logic [4:0]    d_rsh_amt;
    logic [2*MW-1:0] d_rsh;

    logic          r_inc;
    logic [W-1:0]  r_mag;
    logic [W-1:0]  r_val;

    assign s2_load  = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_load;
    assign in_fire  = in_valid & in_ready;

    // Stage 1 decode: classify, then denormalise by a left or right barrel shift.
    // Zero, denormal and tiny inputs produce magnitude 0 with sticky set when non-zero.
    always_comb begin
        d_exp     = in_data[30:23];
        d_frac    = in_data[22:0];
        d_m       = {1'b1, d_frac};
        d_lsh_amt = 4'(d_exp - 8'd150);
        d_rsh_amt = 5'(8'd150 - d_exp);
        d_rsh     = {d_m, 24'd0} >> d_rsh_amt;
        d_sign    = in_data[31];
        d_sat     = 1'b0;
        d_mag     = '0;
        d_g       = 1'b0;
        d_r       = 1'b0;
        d_s       = 1'b0;
        if (d_exp == 8'd255) begin
            d_sat = 1'b1;
            if (d_frac != 23'd0) begin
                d_sign = 1'b0;
            end
        end else if ((d_exp > 8'd158) ||
                     ((d_exp == 8'd158) && !(in_data[31] && (d_frac == 23'd0)))) begin
            d_sat = 1'b1;
        end else if (d_exp >= 8'd150) begin
            d_mag = W'(d_m) << d_lsh_amt;
        end else if (d_exp >= 8'd126) begin
            d_mag = W'(d_rsh[2*MW-1:MW]);
            d_g   = d_rsh[MW-1];
            d_r   = d_rsh[MW-2];
            d_s   = |d_rsh[MW-3:0];
        end else begin
            d_s = |in_data[30:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Payload loads only on a real transfer so idle in_data never reaches state.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_sign <= 1'b0;
            s1_sat  <= 1'b0;
            s1_g    <= 1'b0;
            s1_r    <= 1'b0;
            s1_s    <= 1'b0;
            s1_mag  <= '0;
        end else if (in_fire) begin
            s1_sign <= d_sign;
            s1_sat  <= d_sat;
            s1_g    <= d_g;
            s1_r    <= d_r;
            s1_s    <= d_s;
            s1_mag  <= d_mag;
        end
    end

    // Stage 2: round half to even, apply sign, then saturate.
    always_comb begin
        r_inc = s1_g & (s1_r | s1_s | s1_mag[0]);
        r_mag = s1_mag + W'(r_inc);
        r_val = s1_sign ? (W'(0) - r_mag) : r_mag;
        if (s1_sat) begin
            r_val = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= OUT_W'(r_val);
            end
        end
    end

`ifdef FTOI_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            out_flags <= 2'b00;
        end else if (s2_load && s1_valid) begin
            out_flags <= {s1_sat, ~s1_sat & (s1_g | s1_r | s1_s)};
        end
    end
`endif

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed bench for ftoi_pipe: arithmetic reference model, stream scoreboard and literal vectors.
module tb_ftoi_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  dut_flags;

    int n_chk = 0;
    int n_err = 0;

`ifdef FTOI_FLAGS_EN
    localparam logic [1:0] FMASK = 2'b11;
    logic [1:0] out_flags;
    assign dut_flags = out_flags;
`else
    localparam logic [1:0] FMASK = 2'b00;
    assign dut_flags = 2'b00;
`endif

    ftoi_pipe #(.OUT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FTOI_FLAGS_EN
        ,
        .out_flags (out_flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: value = m * 2^(E-150); integer quotient plus remainder decides the rounding.
    function automatic logic [33:0] model(input logic [31:0] x);
        logic        sgn;
        int          ex;
        int          k;
        longint      m;
        longint      q;
        longint      rem;
        longint      half;
        longint      v;
        logic        inv;
        logic        inx;
        logic [31:0] d;
        sgn = x[31];
        ex  = int'(x[30:23]);
        m   = (ex == 0) ? longint'(x[22:0]) : longint'({1'b1, x[22:0]});
        inv = 1'b0;
        inx = 1'b0;
        d   = 32'd0;
        rem = 0;
        if (ex == 255) begin
            inv = 1'b1;
            d = ((x[22:0] != 23'd0) || !sgn) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else if (ex > 158) begin
            inv = 1'b1;
            d = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            k = 150 - ex;
            if (k <= 0) begin
                q = m << (-k);
            end else if (k >= 40) begin
                q = 0;
                rem = m;
            end else begin
                q = m >> k;
                rem = m - (q << k);
                half = longint'(1) << (k - 1);
                if ((rem > half) || ((rem == half) && (q % 2 == 1))) q = q + 1;
            end
            v = sgn ? -q : q;
            if (v > 64'sd2147483647) begin
                inv = 1'b1;
                d = 32'h7FFF_FFFF;
            end else if (v < -64'sd2147483648) begin
                inv = 1'b1;
                d = 32'h8000_0000;
            end else begin
                d = 32'(v);
                inx = (rem != 0);
            end
        end
        return {inv, inx, d};
    endfunction

    function automatic logic [33:0] masked(input logic [33:0] w);
        return {w[33:32] & FMASK, w[31:0]};
    endfunction

    // Scoreboard: every accepted operand must come out once, in order, held while stalled.
    logic [33:0] exp_q[$];
    logic        hold = 1'b0;
    logic [33:0] held;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            if (hold) chk("hold", {dut_flags, out_data}, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_out: got %h expected no output at %0t", out_data, $time);
                end else begin
                    chk("stream", {dut_flags, out_data}, masked(exp_q.pop_front()));
                end
            end
            hold = out_valid && !out_ready;
            held = {dut_flags, out_data};
            if (in_valid && in_ready) exp_q.push_back(model(in_data));
        end
    end

    task automatic send_check(input logic [31:0] x, input logic [31:0] d, input logic [1:0] f);
        chk("model", model(x), {f, d});
        in_valid = 1'b1;
        in_data  = x;
        #1;
        chk("accept_ready", 34'(in_ready), 34'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("latency_valid", 34'(out_valid), 34'd1);
        chk("latency_data", {dut_flags, out_data}, {f & FMASK, d});
    endtask

    logic [31:0] vec_in [17] = '{
        32'h3FC0_0000, 32'h4020_0000, 32'hBFC0_0000, 32'h3F00_0000, 32'h3F40_0000,
        32'h0000_0001, 32'h8000_0000, 32'h4B7F_FFFF, 32'h4EFF_FFFF, 32'h4F00_0000,
        32'hCF00_0000, 32'hCF00_0001, 32'h7FC0_0000, 32'hFF80_0000, 32'h3F80_0000,
        32'hC020_0000, 32'h4060_0000};
    logic [31:0] vec_out [17] = '{
        32'h0000_0002, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0001,
        32'h0000_0000, 32'h0000_0000, 32'h00FF_FFFF, 32'h7FFF_FF80, 32'h7FFF_FFFF,
        32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001,
        32'hFFFF_FFFE, 32'h0000_0004};
    logic [1:0] vec_flg [17] = '{
        2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
        2'b01, 2'b00, 2'b00, 2'b00, 2'b10,
        2'b00, 2'b10, 2'b10, 2'b10, 2'b00,
        2'b01, 2'b01};

    logic [31:0] bp_in [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

    initial begin
        logic [31:0] got [4];
        int          got_cyc [4];
        int          ng;
        int          ni;
        logic        acc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 34'(out_valid), 34'd0);
        chk("reset_data", {dut_flags, out_data}, 34'd0);
        reset = 1'b0;
        #1;
        chk("reset_in_ready", 34'(in_ready), 34'd1);

        for (int i = 0; i < 17; i++) send_check(vec_in[i], vec_out[i], vec_flg[i]);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: consumer stalled for the first three cycles of a 4-item burst.
        ng = 0;
        ni = 0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            out_ready = (c >= 3);
            in_valid  = (ni < 4);
            in_data   = (ni < 4) ? bp_in[ni] : 32'hDEAD_BEEF;
            #1;
            acc = in_valid && in_ready;
            if (c == 2) begin
                chk("bp_in_ready_low", 34'(in_ready), 34'd0);
                chk("bp_hold_valid", 34'(out_valid), 34'd1);
                chk("bp_hold_data", 34'(out_data), 34'h1);
            end
            if (out_valid && out_ready) begin
                got[ng]     = out_data;
                got_cyc[ng] = c;
                ng++;
            end
            @(posedge clk); #1;
            if (acc) ni++;
        end
        in_valid  = 1'b0;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        chk("bp_count", 34'(ng), 34'd4);
        for (int k = 0; k < ng; k++) begin
            chk("bp_order", 34'(got[k]), 34'(k + 1));
            chk("bp_consecutive", 34'(got_cyc[k]), 34'(3 + k));
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset with two items in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h3F80_0000;
        @(posedge clk); #1;
        in_data   = 32'h4000_0000;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_data   = 32'hDEAD_BEEF;
        chk("flight_valid", 34'(out_valid), 34'd1);
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset_valid", 34'(out_valid), 34'd0);
        chk("midreset_data", {dut_flags, out_data}, 34'd0);
        #1;
        chk("midreset_in_ready", 34'(in_ready), 34'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("no_stale", 34'(out_valid), 34'd0);
        send_check(32'h4120_0000, 32'h0000_000A, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        chk("drain", 34'(exp_q.size()), 34'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ftoi_pipe.md
Name: ftoi_pipe

Overview:
- Pipelined IEEE-754 single-precision to signed 32-bit integer converter for the FPU.
- Does the reverse of the adder's normalise-and-pack path: it unpacks sign, exponent and mantissa, denormalises by a barrel shift, rounds, and applies two's-complement sign.
- Sits beside fadd in the FPU execute stage. Two-stage pipeline with valid/ready handshakes on both sides, accepting one operand per cycle.

Parameters:
- OUT_W, 32, integer result width. Only 32 is supported; the parameter exists for port sizing only.

Ports:
- clk  input  1  clock, all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  converter can accept in_data this cycle.
- in_data  input  32  single-precision operand.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  OUT_W  signed integer result.
- out_flags  output  2  present only with FTOI_FLAGS_EN; bit1 = invalid, bit0 = inexact.

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_flags=0, stage-1 valid=0. in_ready=1 in the cycle after reset deasserts.
- Handshake:
  - Input transfer happens when in_valid & in_ready.
  - Output transfer happens when out_valid & out_ready.
  - out_data and out_flags are held stable while out_valid & ~out_ready.
- Pipeline control:
  - Stage 2 (output register) loads when it is empty or out_ready=1.
  - Stage 1 advances whenever stage 2 loads.
  - in_ready = ~s1_valid | s2_load. This is combinational from out_ready; no other combinational input-to-output path is allowed.
- Latency and throughput:
  - Accept in cycle N gives out_valid in cycle N+2 with no backpressure.
  - Throughput is 1 per cycle.
  - Ordering is preserved.
  - At most 2 items in flight.
- Stage 1 (decode and shift):
  - s=in[31], E=in[30:23], F=in[22:0], m={1,F} (24 bits), e=E-127.
  - Classify: NaN (E=255, F≠0); inf (E=255, F=0); zero/denormal (E=0, treated as 0); tiny (E<126); overflow (e≥31, except exactly s=1, E=158, F=0); normal.
  - e in 23..30: magnitude = m << (e-23); exact.
  - e in -1..22: magnitude = m >> (23-e), keeping guard bit G, round bit R and sticky S (OR of the remaining shifted-out bits).
  - Register s, magnitude, G/R/S and class.
- Stage 2 (round, sign, saturate):
  - Round to nearest, ties to even: increment when G & (R | S | lsb).
  - Rounding cannot overflow, since pre-round magnitude < 2^24 whenever a right shift occurred.
  - Negate (two's complement) when s=1.
- Saturation and special cases:
  - NaN, +inf, positive overflow → 0x7FFFFFFF.
  - -inf, negative overflow → 0x80000000.
  - Exactly -2^31 (0xCF000000) → 0x80000000, exact and not invalid.
  - Zero, denormal, tiny → 0. -0.0 → 0x00000000.
  - E=126 goes through the normal path: 0.5 rounds to 0, anything above 0.5 rounds to 1.
- Simultaneous events: s2_load together with an input accept moves stage 1 into stage 2 and the new operand into stage 1 in the same edge.
- Reset mid-operation: all in-flight items are discarded. out_valid=0 on the cycle after the reset edge, and no stale result appears after release.
- in_data is ignored when in_valid=0; X on in_data must not propagate into state.

Optional Feature:
- Macro: FTOI_FLAGS_EN.
- Defined:
  - out_flags exists and is registered alongside out_data.
  - invalid is set for NaN, inf and overflow.
  - inexact is set when G|R|S ≠ 0 on a non-invalid result, including tiny non-zero inputs.
  - Stage 1 carries the class and sticky bits to produce the flags.
- Undefined: out_flags is omitted and no flag logic is built. All other behaviour is identical.

Test Plan:
- Rounding, no backpressure: 0x3FC00000 (1.5)→0x00000002; 0x40200000 (2.5)→0x00000002; 0xBFC00000 (-1.5)→0xFFFFFFFE. Each out_valid 2 cycles after accept; flags inexact=1.
- Boundaries: 0x3F000000 (0.5)→0; 0x3F400000 (0.75)→1; 0x00000001 (denormal)→0 with inexact=1; 0x80000000→0; 0x4B7FFFFF→0x00FFFFFF exact; 0x4EFFFFFF→0x7FFFFF80 exact.
- Saturation: 0x4F000000→0x7FFFFFFF invalid; 0xCF000000→0x80000000 no flags; 0xCF000001→0x80000000 invalid; 0x7FC00000→0x7FFFFFFF invalid; 0xFF800000→0x80000000 invalid.
- Backpressure: stream 1.0, 2.0, 3.0, 4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000) back-to-back with out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepts and out_data holds 1 stable.
  - After release, outputs 1, 2, 3, 4 appear on consecutive cycles with none lost or duplicated.
- Reset mid-flight: 2 items in flight, reset high for 1 cycle → out_valid=0 and out_data=0 the next cycle; in_ready=1 after release; the next input 0x41200000 (10.0) → 0x0000000A.
